// File: rtl/rf_wb_arbiter_if.sv
// Writeback request bus and register-file write-port bundle
// shared between writeback requesters and rf_wb_arbiter.
interface rf_wb_arbiter_if #(
  parameter int NREQ = 3,
  parameter int XLEN = 32,
  parameter int AW   = 5
);
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*AW-1:0]   req_addr;
  logic [NREQ*XLEN-1:0] req_data;
  logic                 we3;
  logic [AW-1:0]        wa3;
  logic [XLEN-1:0]      wd3;
  logic                 we4;
  logic [AW-1:0]        wb3;
  logic [XLEN-1:0]      wd4;

  modport master (
    output req_valid, req_addr, req_data,
    input  req_ready,
    input  we3, wa3, wd3, we4, wb3, wd4
  );

  modport slave (
    input  req_valid, req_addr, req_data,
    output req_ready,
    output we3, wa3, wd3, we4, wb3, wd4
  );
endinterface

// File: rtl/rf_wb_arbiter.sv
// Round-robin arbiter granting up to two register-file writes per cycle.
// Optional RFARB_CONFLICT_CNT_EN adds a saturating conflict_cnt output.
module rf_wb_arbiter #(
  parameter int NREQ = 3,
  parameter int XLEN = 32,
  parameter int AW   = 5
) (
  input  logic clk,
  input  logic reset,
  rf_wb_arbiter_if.slave bus
`ifdef RFARB_CONFLICT_CNT_EN
  ,
  output logic [15:0] conflict_cnt
`endif
);

  localparam int PW = $clog2(NREQ);

  logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
  logic            we3_q, we3_d;
  logic [AW-1:0]   wa3_q, wa3_d;
  logic [XLEN-1:0] wd3_q, wd3_d;
  logic            we4_q, we4_d;
  logic [AW-1:0]   wb3_q, wb3_d;
  logic [XLEN-1:0] wd4_q, wd4_d;

  logic [AW-1:0]   addr_a [NREQ];
  logic [XLEN-1:0] data_a [NREQ];
  logic [NREQ-1:0] ready;
  logic            a_gnt, b_gnt, conflict;
  logic [AW-1:0]   a_addr, b_addr;
  logic [XLEN-1:0] a_data, b_data;
  logic [PW-1:0]   last;
  logic [PW:0]     last_inc;

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      addr_a[i] = bus.req_addr[i*AW +: AW];
      data_a[i] = bus.req_data[i*XLEN +: XLEN];
    end
  end

  // x0 writes are acknowledged and dropped without using a port
  always_comb begin : grant
    logic [PW:0]   jw;
    logic [PW-1:0] j;
    ready    = '0;
    a_gnt    = 1'b0;
    b_gnt    = 1'b0;
    a_addr   = '0;
    a_data   = '0;
    b_addr   = '0;
    b_data   = '0;
    last     = '0;
    conflict = 1'b0;
    jw       = '0;
    j        = '0;
    for (int i = 0; i < NREQ; i++) begin
      jw = {1'b0, rr_ptr_q} + (PW+1)'(i);
      if (jw >= (PW+1)'(NREQ))
        jw = jw - (PW+1)'(NREQ);
      j = jw[PW-1:0];
      if (bus.req_valid[j]) begin
        if (addr_a[j] == '0) begin
          ready[j] = 1'b1;
        end else if (!a_gnt) begin
          a_gnt    = 1'b1;
          a_addr   = addr_a[j];
          a_data   = data_a[j];
          ready[j] = 1'b1;
          last     = j;
        end else if (!b_gnt && addr_a[j] != a_addr) begin
          b_gnt    = 1'b1;
          b_addr   = addr_a[j];
          b_data   = data_a[j];
          ready[j] = 1'b1;
          last     = j;
        end else begin
          conflict = 1'b1;
        end
      end
    end
    if (reset) begin
      ready    = '0;
      a_gnt    = 1'b0;
      b_gnt    = 1'b0;
      conflict = 1'b0;
    end
  end

  always_comb begin
    last_inc = {1'b0, last} + (PW+1)'(1);
    rr_ptr_d = rr_ptr_q;
    if (a_gnt || b_gnt)
      rr_ptr_d = (last_inc >= (PW+1)'(NREQ)) ? '0 : last_inc[PW-1:0];
    we3_d = a_gnt;
    wa3_d = a_gnt ? a_addr : wa3_q;
    wd3_d = a_gnt ? a_data : wd3_q;
    we4_d = b_gnt;
    wb3_d = b_gnt ? b_addr : wb3_q;
    wd4_d = b_gnt ? b_data : wd4_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_q <= '0;
      we3_q    <= 1'b0;
      wa3_q    <= '0;
      wd3_q    <= '0;
      we4_q    <= 1'b0;
      wb3_q    <= '0;
      wd4_q    <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      we3_q    <= we3_d;
      wa3_q    <= wa3_d;
      wd3_q    <= wd3_d;
      we4_q    <= we4_d;
      wb3_q    <= wb3_d;
      wd4_q    <= wd4_d;
    end
  end

  assign bus.req_ready = ready;
  assign bus.we3       = we3_q;
  assign bus.wa3       = wa3_q;
  assign bus.wd3       = wd3_q;
  assign bus.we4       = we4_q;
  assign bus.wb3       = wb3_q;
  assign bus.wd4       = wd4_q;

`ifdef RFARB_CONFLICT_CNT_EN
  logic [15:0] conflict_cnt_q, conflict_cnt_d;

  always_comb begin
    conflict_cnt_d = conflict_cnt_q;
    if (conflict && conflict_cnt_q != 16'hFFFF)
      conflict_cnt_d = conflict_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset)
      conflict_cnt_q <= '0;
    else
      conflict_cnt_q <= conflict_cnt_d;
  end

  assign conflict_cnt = conflict_cnt_q;
`endif

endmodule
